pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Parametrised next-generation program-counter unit for the MIPS datapath.
- Owns the PC register and computes the sequential, branch, pseudo-direct jump and jump-register targets internally.
- Adds a return-address stack (RAS) with prediction-check flags, and a stall hold.
- Sits between the controller/ALU (branch decision, rs data) and instruction memory (pc output).

Parameters:
- ADDR_W, 32: PC/address width; must be at least JIDX_W+2.
- JIDX_W, 26: jump-index field width (instr[JIDX_W-1:0]).
- IMM_W, 16: branch immediate width (instr[IMM_W-1:0]), sign-extended.
- RAS_DEPTH, 4: return-address stack entries; power of two, at least 2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold all state this cycle.
- instr  in  32  current instruction word.
- rs_data  in  ADDR_W  register-file rs value, used as the jr target.
- branch_taken  in  1  branch condition resolved true.
- jump_en  in  1  j instruction.
- jal_en  in  1  jal instruction; jumps and pushes the return address.
- jr_en  in  1  jr instruction.
- pc  out  ADDR_W  current PC (registered).
- pc_plus4  out  ADDR_W  pc+4, combinational.
- ras_top  out  ADDR_W  top-of-stack entry; 0 when empty.
- ras_empty  out  1  stack holds no entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_overflow  out  1  sticky; set when a push occurs while full.
- ras_mispredict  out  1  one-cycle registered pulse on a jr-to-$ra mismatch.

Behaviour:
- Reset (rst=1 at an edge, overrides stall and all selects):
  - pc=RESET_PC; stack pointer=0; ras_overflow=0; ras_mispredict=0; all RAS entries cleared to 0.
- Target arithmetic:
  - seq = pc+4, modulo 2^ADDR_W (wrap-around from all-ones-minus-3 to 0).
  - br = pc+4 + (sext(instr[IMM_W-1:0]) << 2), truncated to ADDR_W.
  - jmp = {pc[ADDR_W-1:JIDX_W+2], instr[JIDX_W-1:0], 2'b00}. Upper bits come from the current pc, not pc+4.
  - jr = rs_data.
- Next-PC priority when stall=0: jr_en > (jal_en | jump_en) > branch_taken > seq. Multiple asserted selects resolve by this priority only.
- Latency: pc updates one cycle after the select inputs; pc_plus4 is combinational from pc.
- Stall=1: pc, RAS, ras_overflow hold. ras_mispredict is forced to 0 that cycle.
- RAS push:
  - Occurs when jal_en=1, jr_en=0 and stall=0; writes pc+4.
  - If not full, pointer increments.
  - If full, the oldest entry is overwritten (circular buffer), the count stays RAS_DEPTH and ras_overflow is set.
- RAS pop:
  - Occurs when jr_en=1, instr[25:21]==5'd31 and stall=0.
  - Not empty: pointer decrements, and ras_mispredict registers (rs_data != ras_top).
  - Empty: no pop; ras_mispredict=1.
  - jr on any other register: no RAS change, ras_mispredict=0.
- Push and pop in the same cycle are impossible: jr priority suppresses the push.
- ras_mispredict is 0 in every cycle without a qualifying pop.
- ras_empty / ras_full are derived from the registered count (0..RAS_DEPTH).

Decomposition:
- Shared package mips_pkg:
  - opcode/funct constants
  - RA_REG=5'd31
  - next-PC select enum {SEL_SEQ, SEL_BR, SEL_JMP, SEL_JR}
  - the jump-target packing function, shared with other datapath users
- One sub-module: ras_stack (circular LIFO with count, push/pop, overwrite-on-full, top output), parametrised by ADDR_W and RAS_DEPTH.

Test Plan:
- Reset/sequential: rst for 2 cycles, then 3 idle cycles -> pc = 0, 0 during reset, then 4, 8, 12; ras_empty=1, ras_top=0.
- Jump target: pc=32'h8000_0000, instr=32'h03FC_0E3B, jump_en=1 -> next pc=32'h8FF0_38EC.
- Branch: pc=32'h0000_0100, instr imm=16'hFFFE, branch_taken=1 -> next pc=32'h0000_00FC. Repeat with branch_taken and jump_en both high -> jump target wins.
- Call/return:
  - jal at pc=32'h40 -> ras_top=32'h44.
  - jr $ra with rs_data=32'h44 -> pc=32'h44, ras_mispredict=0, ras_empty=1.
  - Repeat with rs_data=32'h48 -> ras_mispredict pulses 1 for exactly one cycle.
- Overflow/underflow:
  - 5 consecutive jals at pc=0x10,0x20,0x30,0x40,0x50 with RAS_DEPTH=4 -> ras_full=1, ras_overflow=1, stack holds 0x24..0x54.
  - 4 pops -> tops 0x54,0x44,0x34,0x24.
  - 5th jr $ra -> ras_mispredict=1, empty unchanged.
- Stall/reset priority:
  - stall=1 with jal_en=1 -> pc and RAS unchanged.
  - rst=1 with stall=1 -> pc=RESET_PC, ras_overflow=0.
  - pc=32'hFFFF_FFFC sequential -> wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: opcode/funct constants, next-PC select
// encoding and the pseudo-direct jump-target packing helper.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [4:0] RA_REG = 5'd31;

    // Widest address the packing helper supports; callers truncate.
    localparam int unsigned JT_MAX_W = 64;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_JR
    } next_pc_sel_e;

    // Keeps pc bits above the word-aligned jump index and replaces the rest
    // with {index, 2'b00}. Index bits above jidx_w are discarded.
    function automatic logic [JT_MAX_W-1:0] jump_target(
        input logic [JT_MAX_W-1:0] pc_val,
        input logic [JT_MAX_W-1:0] idx,
        input int unsigned         jidx_w
    );
        logic [JT_MAX_W-1:0] mask;
        mask = (JT_MAX_W'(1) << (jidx_w + 2)) - JT_MAX_W'(1);
        return (pc_val & ~mask) | ((idx << 2) & mask);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, top reads 0 when empty.
module ras_stack
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] entry_reg [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [PTR_W-1:0]  top_idx;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(RAS_DEPTH));
    assign top_idx = ptr_reg - PTR_W'(1);
    assign top     = empty ? '0 : entry_reg[top_idx];
    assign overflow = overflow_reg;

    // ptr_reg is the next write slot; it wraps naturally since depth is 2^n.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg[gi] <= '0;
                end else if (push && ptr_reg == PTR_W'(gi)) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg      <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (push) begin
            ptr_reg <= ptr_reg + PTR_W'(1);
            if (full) begin
                overflow_reg <= 1'b1;
            end else begin
                count_reg <= count_reg + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg   <= ptr_reg - PTR_W'(1);
            count_reg <= count_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: owns the PC, computes seq/branch/jump/jr targets and
// tracks calls/returns in a return-address stack with mispredict checking.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       JIDX_W    = 26,
    parameter int unsigned       IMM_W     = 16,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              branch_taken,
    input  logic              jump_en,
    input  logic              jal_en,
    input  logic              jr_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] ras_top,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_mispredict
);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] jmp_target;
    next_pc_sel_e      sel;
    logic              push;
    logic              pop_req;
    logic              mispredict_reg;
    logic              mispredict_next;
    logic              unused_instr;

    assign unused_instr = ^instr;

    assign pc        = pc_reg;
    assign pc_plus4  = pc_reg + ADDR_W'(4);
    assign imm_ext   = {{(ADDR_W - IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
    assign br_target = pc_plus4 + (imm_ext << 2);
    // Upper jump bits come from the current pc, not pc+4.
    assign jmp_target = ADDR_W'(jump_target(JT_MAX_W'(pc_reg), JT_MAX_W'(instr), JIDX_W));

    always_comb begin
        sel     = SEL_SEQ;
        pc_next = pc_plus4;
        if (jr_en) begin
            sel = SEL_JR;
        end else if (jal_en || jump_en) begin
            sel = SEL_JMP;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end
        case (sel)
            SEL_JR:  pc_next = rs_data;
            SEL_JMP: pc_next = jmp_target;
            SEL_BR:  pc_next = br_target;
            default: pc_next = pc_plus4;
        endcase
    end

    // jr takes priority, so a jal alongside jr never pushes.
    assign push    = jal_en && !jr_en && !stall;
    assign pop_req = jr_en && (instr[25:21] == RA_REG) && !stall;
    assign mispredict_next = pop_req && (ras_empty || (rs_data != ras_top));

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg         <= RESET_PC;
            mispredict_reg <= 1'b0;
        end else begin
            mispredict_reg <= mispredict_next;
            if (!stall) begin
                pc_reg <= pc_next;
            end
        end
    end

    assign ras_mispredict = mispredict_reg;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop_req),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .overflow  (ras_overflow)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, target arithmetic, priority,
// call/return stack behaviour, stall and wrap-around.
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic        branch_taken;
    logic        jump_en;
    logic        jal_en;
    logic        jr_en;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] ras_top;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_mispredict;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] JR_RA  = 32'h03E0_0008;
    localparam logic [31:0] JR_R0  = 32'h0000_0008;
    localparam logic [31:0] JAL_I0 = 32'h0C00_0000;

    pc_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .instr          (instr),
        .rs_data        (rs_data),
        .branch_taken   (branch_taken),
        .jump_en        (jump_en),
        .jal_en         (jal_en),
        .jr_en          (jr_en),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .ras_top        (ras_top),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full),
        .ras_overflow   (ras_overflow),
        .ras_mispredict (ras_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        stall = 0; instr = '0; rs_data = '0;
        branch_taken = 0; jump_en = 0; jal_en = 0; jr_en = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b stall=%0b pc=%h top=%h emp=%0b full=%0b ovf=%0b misp=%0b",
                 $time, rst, stall, pc, ras_top, ras_empty, ras_full, ras_overflow, ras_mispredict);
        idle_inputs();
    endtask

    // Load an arbitrary pc via jr on a non-$ra register (no RAS effect).
    task automatic set_pc(input logic [31:0] target);
        jr_en = 1; instr = JR_R0; rs_data = target;
        step();
    endtask

    task automatic do_reset();
        rst = 1; step(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc0 got %h exp %h", pc, 32'h0); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc1 got %h exp %h", pc, 32'h0); end
        checks++; if (ras_empty !== 1'b1 || ras_top !== 32'h0) begin errors++;
            $display("FAIL reset_ras got empty=%0b top=%h exp 1 0", ras_empty, ras_top); end
        checks++; if (ras_mispredict !== 1'b0 || ras_overflow !== 1'b0) begin errors++;
            $display("FAIL reset_flags got misp=%0b ovf=%0b exp 0 0", ras_mispredict, ras_overflow); end
        rst = 0;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++; if (pc !== 32'(4 * i)) begin errors++; $display("FAIL seq%0d got %h exp %h", i, pc, 32'(4 * i)); end
        end
        checks++; if (pc_plus4 !== 32'd16) begin errors++; $display("FAIL pc_plus4 got %h exp %h", pc_plus4, 32'd16); end
    endtask

    task automatic test_jump();
        set_pc(32'h8000_0000);
        checks++; if (pc !== 32'h8000_0000) begin errors++; $display("FAIL jr_load got %h exp %h", pc, 32'h8000_0000); end
        checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL jr_nonra_misp got %0b exp 0", ras_mispredict); end
        jump_en = 1; instr = 32'h03FC_0E3B;
        step();
        checks++; if (pc !== 32'h8FF0_38EC) begin errors++; $display("FAIL jump_target got %h exp %h", pc, 32'h8FF0_38EC); end
    endtask

    task automatic test_branch();
        set_pc(32'h0000_0100);
        branch_taken = 1; instr = 32'h0000_FFFE;
        step();
        checks++; if (pc !== 32'h0000_00FC) begin errors++; $display("FAIL branch_back got %h exp %h", pc, 32'h0000_00FC); end
        set_pc(32'h0000_0100);
        branch_taken = 1; jump_en = 1; instr = 32'h0000_FFFE;
        step();
        checks++; if (pc !== 32'h0003_FFF8) begin errors++; $display("FAIL jump_over_branch got %h exp %h", pc, 32'h0003_FFF8); end
        branch_taken = 1; jump_en = 1; jr_en = 1; instr = 32'h0000_FFFE; rs_data = 32'h0000_0200;
        step();
        checks++; if (pc !== 32'h0000_0200) begin errors++; $display("FAIL jr_over_all got %h exp %h", pc, 32'h0000_0200); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL jr_no_push got empty=%0b exp 1", ras_empty); end
    endtask

    task automatic test_call_return();
        do_reset();
        set_pc(32'h40);
        jal_en = 1; instr = 32'h0C00_0030;
        step();
        checks++; if (pc !== 32'hC0) begin errors++; $display("FAIL jal_pc got %h exp %h", pc, 32'hC0); end
        checks++; if (ras_top !== 32'h44 || ras_empty !== 1'b0) begin errors++;
            $display("FAIL jal_push got top=%h empty=%0b exp 44 0", ras_top, ras_empty); end
        jr_en = 1; instr = JR_RA; rs_data = 32'h44;
        step();
        checks++; if (pc !== 32'h44 || ras_mispredict !== 1'b0 || ras_empty !== 1'b1) begin errors++;
            $display("FAIL ret_ok got pc=%h misp=%0b empty=%0b exp 44 0 1", pc, ras_mispredict, ras_empty); end
        set_pc(32'h40);
        jal_en = 1; instr = 32'h0C00_0030;
        step();
        jr_en = 1; instr = JR_RA; rs_data = 32'h48;
        step();
        checks++; if (ras_mispredict !== 1'b1 || pc !== 32'h48) begin errors++;
            $display("FAIL ret_bad got misp=%0b pc=%h exp 1 48", ras_mispredict, pc); end
        step();
        checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL misp_pulse got %0b exp 0", ras_mispredict); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_top;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            set_pc(32'(16 * i));
            jal_en = 1; instr = JAL_I0;
            step();
        end
        checks++; if (ras_full !== 1'b1 || ras_overflow !== 1'b1) begin errors++;
            $display("FAIL ovf_flags got full=%0b ovf=%0b exp 1 1", ras_full, ras_overflow); end
        for (int i = 5; i >= 2; i--) begin
            exp_top = 32'(16 * i + 4);
            checks++; if (ras_top !== exp_top) begin errors++; $display("FAIL pop_top%0d got %h exp %h", i, ras_top, exp_top); end
            jr_en = 1; instr = JR_RA; rs_data = exp_top;
            step();
            checks++; if (ras_mispredict !== 1'b0) begin errors++; $display("FAIL pop_misp%0d got %0b exp 0", i, ras_mispredict); end
        end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++;
            $display("FAIL drained got empty=%0b full=%0b exp 1 0", ras_empty, ras_full); end
        jr_en = 1; instr = JR_RA; rs_data = 32'h0;
        step();
        checks++; if (ras_mispredict !== 1'b1 || ras_empty !== 1'b1 || ras_overflow !== 1'b1) begin errors++;
            $display("FAIL underflow got misp=%0b empty=%0b ovf=%0b exp 1 1 1", ras_mispredict, ras_empty, ras_overflow); end
    endtask

    task automatic test_stall();
        set_pc(32'h300);
        stall = 1; jal_en = 1; instr = 32'h0C00_0030;
        step();
        checks++; if (pc !== 32'h300 || ras_empty !== 1'b1) begin errors++;
            $display("FAIL stall_hold got pc=%h empty=%0b exp 300 1", pc, ras_empty); end
        stall = 1; jr_en = 1; instr = JR_RA; rs_data = 32'h1;
        step();
        checks++; if (ras_mispredict !== 1'b0 || pc !== 32'h300) begin errors++;
            $display("FAIL stall_jr got misp=%0b pc=%h exp 0 300", ras_mispredict, pc); end
        rst = 1; stall = 1; jump_en = 1; instr = 32'h0800_00FF;
        @(posedge clk); #1;
        rst = 0; idle_inputs();
        checks++; if (pc !== 32'h0 || ras_overflow !== 1'b0) begin errors++;
            $display("FAIL rst_over_stall got pc=%h ovf=%0b exp 0 0", pc, ras_overflow); end
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        checks++; if (pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_plus4 got %h exp %h", pc_plus4, 32'h0); end
        step();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h exp %h", pc, 32'h0); end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_jump();
        test_branch();
        test_call_return();
        test_overflow();
        test_stall();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
